// File: rtl/fp32_pkg.sv
// rtl/fp32_pkg.sv - binary32 field widths, operand types, classes and flag bit positions.
package fp32_pkg;
    localparam int EXP_W   = 8;
    localparam int MAN_W   = 23;
    localparam int BIAS    = 127;
    localparam int EXP_MAX = 2 * BIAS + 1;

    localparam int FLAG_NV = 3;
    localparam int FLAG_OF = 2;
    localparam int FLAG_UF = 1;
    localparam int FLAG_NX = 0;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [MAN_W-1:0] man;
    } fp32_t;

    typedef enum logic [2:0] {ZERO, SUB, NORM, INF, QNAN, SNAN} fp_class_e;

    function automatic fp_class_e fp_classify(input fp32_t x);
        fp_class_e c;
        if (x.exp == '0)
            c = (x.man == '0) ? ZERO : SUB;
        else if (x.exp == 8'(EXP_MAX))
            c = (x.man == '0) ? INF : (x.man[MAN_W-1] ? QNAN : SNAN);
        else
            c = NORM;
        return c;
    endfunction
endpackage

// File: rtl/fp_lzc.sv
// rtl/fp_lzc.sv - combinational 28-bit leading-zero counter (all-zero input counts 28).
module fp_lzc (
    input  logic [27:0] value,
    output logic [4:0]  count
);
    always_comb begin
        count = 5'd28;
        for (int i = 0; i < 28; i++)
            if (value[i]) count = 5'(27 - i);
    end
endmodule

// File: rtl/fp_sub.sv
// rtl/fp_sub.sv - pipelined binary32 subtractor res = op_1 - op_2; FP_SUB_FTZ_EN selects flush-to-zero.
module fp_sub
    import fp32_pkg::*;
#(
    parameter logic [31:0] QNAN = 32'h7FC0_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic [31:0] op_1,
    input  logic [31:0] op_2,
    output logic [31:0] res,
    output logic        val,
    output logic [3:0]  flags
);
    logic  v0;
    fp32_t a0, b0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v0 <= 1'b0;
            a0 <= '0;
            b0 <= '0;
        end else begin
            v0 <= en;
            if (en) begin
                a0 <= op_1;
                b0 <= op_2;
            end
        end
    end

    // S1: classify, swap so A has the larger magnitude, align B with guard/round/sticky
    fp_class_e   ca, cb;
    logic [23:0] sig_1, sig_2, sig_big, sig_small;
    logic [7:0]  exp_1, exp_2, exp_big, exp_small, diff;
    logic [4:0]  dc;
    logic [26:0] wide, shifted, aligned;
    logic        swap, sign_big, lost;
    logic        spec, spec_nv;
    logic [31:0] spec_res;

    assign ca = fp_classify(a0);
    assign cb = fp_classify(b0);
`ifdef FP_SUB_FTZ_EN
    assign sig_1 = (ca == NORM) ? {1'b1, a0.man} : 24'd0;
    assign sig_2 = (cb == NORM) ? {1'b1, b0.man} : 24'd0;
`else
    assign sig_1 = {a0.exp != 8'd0, a0.man};
    assign sig_2 = {b0.exp != 8'd0, b0.man};
`endif
    assign exp_1     = (a0.exp == 8'd0) ? 8'd1 : a0.exp;
    assign exp_2     = (b0.exp == 8'd0) ? 8'd1 : b0.exp;
    assign swap      = {exp_2, sig_2} > {exp_1, sig_1};
    assign sig_big   = swap ? sig_2 : sig_1;
    assign sig_small = swap ? sig_1 : sig_2;
    assign exp_big   = swap ? exp_2 : exp_1;
    assign exp_small = swap ? exp_1 : exp_2;
    assign sign_big  = swap ? ~b0.sign : a0.sign;
    assign diff      = exp_big - exp_small;
    assign dc        = (diff > 8'd27) ? 5'd27 : diff[4:0];
    assign wide      = {sig_small, 3'b000};
    assign shifted   = wide >> dc;
    assign lost      = |(wide & ~(27'h7FF_FFFF << dc));
    assign aligned   = shifted | {26'd0, lost};

    always_comb begin
        spec     = 1'b0;
        spec_nv  = 1'b0;
        spec_res = QNAN;
        if (ca == SNAN || ca == fp32_pkg::QNAN || cb == SNAN || cb == fp32_pkg::QNAN) begin
            spec    = 1'b1;
            spec_nv = (ca == SNAN) || (cb == SNAN);
        end else if (ca == INF && cb == INF && a0.sign == b0.sign) begin
            spec    = 1'b1;
            spec_nv = 1'b1;
        end else if (ca == INF) begin
            spec     = 1'b1;
            spec_res = {a0.sign, 8'hFF, 23'd0};
        end else if (cb == INF) begin
            spec     = 1'b1;
            spec_res = {~b0.sign, 8'hFF, 23'd0};
        end
    end

    logic        v1, spec1, nv1, sign1, sub1;
    logic [31:0] spec_res1;
    logic [7:0]  exp1;
    logic [26:0] ma1, mb1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v1 <= 1'b0; spec1 <= 1'b0; nv1 <= 1'b0; sign1 <= 1'b0; sub1 <= 1'b0;
            spec_res1 <= '0; exp1 <= '0; ma1 <= '0; mb1 <= '0;
        end else begin
            v1 <= v0;
            if (v0) begin
                spec1 <= spec; nv1 <= spec_nv; spec_res1 <= spec_res;
                sign1 <= sign_big; sub1 <= a0.sign ^ ~b0.sign;
                exp1 <= exp_big; ma1 <= {sig_big, 3'b000}; mb1 <= aligned;
            end
        end
    end

    // S2: magnitude add or subtract; an exact-zero difference is +0
    logic [27:0] sum;
    logic [4:0]  lz;

    assign sum = sub1 ? ({1'b0, ma1} - {1'b0, mb1}) : ({1'b0, ma1} + {1'b0, mb1});

    fp_lzc u_lzc (.value(sum), .count(lz));

    logic        v2, spec2, nv2, sign2;
    logic [31:0] spec_res2;
    logic [7:0]  exp2;
    logic [27:0] r2;
    logic [4:0]  lz2;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v2 <= 1'b0; spec2 <= 1'b0; nv2 <= 1'b0; sign2 <= 1'b0;
            spec_res2 <= '0; exp2 <= '0; r2 <= '0; lz2 <= '0;
        end else begin
            v2 <= v1;
            if (v1) begin
                spec2 <= spec1; nv2 <= nv1; spec_res2 <= spec_res1;
                sign2 <= (sum == 28'd0 && sub1) ? 1'b0 : sign1;
                exp2 <= exp1; r2 <= sum; lz2 <= lz;
            end
        end
    end

    // S3: normalize, round to nearest even, pack
    logic              carry, inc, inexact;
    logic [4:0]        lz_m1, sh;
    logic [26:0]       norm;
    logic [24:0]       mant;
    logic [22:0]       frac;
    logic signed [9:0] exp_n, exp_r;
    logic [31:0]       r_res;
    logic [3:0]        r_flags;

    assign carry = r2[27];
    assign lz_m1 = lz2 - 5'd1;
`ifdef FP_SUB_FTZ_EN
    assign sh = lz_m1;
`else
    logic [7:0] room;
    logic       hid;
    assign room = exp2 - 8'd1;
    assign sh   = ({3'b000, lz_m1} > room) ? room[4:0] : lz_m1;
    assign hid  = mant[24] | mant[23];
`endif
    assign norm    = carry ? {r2[27:2], r2[1] | r2[0]} : (r2[26:0] << sh);
    assign exp_n   = carry ? ($signed({2'b00, exp2}) + 10'sd1)
                           : ($signed({2'b00, exp2}) - $signed({5'd0, sh}));
    assign inc     = norm[2] & (norm[1] | norm[0] | norm[3]);
    assign inexact = |norm[2:0];
    assign mant    = {1'b0, norm[26:3]} + {24'd0, inc};
    assign exp_r   = exp_n + $signed({9'd0, mant[24]});
    assign frac    = mant[24] ? mant[23:1] : mant[22:0];

    always_comb begin
        r_res   = '0;
        r_flags = '0;
        if (spec2) begin
            r_res            = spec_res2;
            r_flags[FLAG_NV] = nv2;
        end else if (r2 == 28'd0) begin
            r_res = {sign2, 31'd0};
        end else if (exp_r >= $signed(10'(EXP_MAX))) begin
            r_res            = {sign2, 8'hFF, 23'd0};
            r_flags[FLAG_OF] = 1'b1;
            r_flags[FLAG_NX] = 1'b1;
        end else begin
`ifdef FP_SUB_FTZ_EN
            if (exp_r < 10'sd1) begin
                r_res            = {sign2, 31'd0};
                r_flags[FLAG_UF] = 1'b1;
                r_flags[FLAG_NX] = 1'b1;
            end else begin
                r_res            = {sign2, exp_r[7:0], frac};
                r_flags[FLAG_NX] = inexact;
            end
`else
            r_res            = {sign2, hid ? exp_r[7:0] : 8'd0, frac};
            r_flags[FLAG_UF] = ~hid & inexact;
            r_flags[FLAG_NX] = inexact;
`endif
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            res   <= '0;
            flags <= '0;
            val   <= 1'b0;
        end else begin
            val <= v2;
            if (v2) begin
                res   <= r_res;
                flags <= r_flags;
            end
        end
    end
endmodule
